// File: rtl/led_serializer.sv
// rtl/led_serializer.sv - shifts a WIDTH-bit word MSB first to an external shift register, then pulses a latch.
// Define LED_SERIALIZER_CHANGE_DETECT_EN to start transfers whenever DATA differs from the last word sent.
module led_serializer #(
  parameter int WIDTH = 32,
  parameter int HALF  = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA,
  input  logic             VALID,
  output logic             READY,
  output logic             SER_DATA,
  output logic             SER_CLK,
  output logic             SER_LATCH,
  output logic             DONE
);

  localparam int BW  = $clog2(WIDTH + 1);
  localparam int HCW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [HCW-1:0] HALF_MAX = HCW'(HALF - 1);
  localparam logic [BW-1:0]  LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [HCW-1:0]   half_q, half_d;
  logic             done_q, done_d;
  logic             start;
  logic             half_last;

`ifdef LED_SERIALIZER_CHANGE_DETECT_EN
  logic [WIDTH-1:0] last_word_q, last_word_d;
  assign start = (DATA != last_word_q);
`else
  assign start = VALID;
`endif

  assign half_last = (half_q == HALF_MAX);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      half_q  <= '0;
      done_q  <= 1'b0;
`ifdef LED_SERIALIZER_CHANGE_DETECT_EN
      last_word_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      half_q  <= half_d;
      done_q  <= done_d;
`ifdef LED_SERIALIZER_CHANGE_DETECT_EN
      last_word_q <= last_word_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    half_d  = half_q;
    done_d  = 1'b0;
`ifdef LED_SERIALIZER_CHANGE_DETECT_EN
    last_word_d = last_word_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = DATA;
          bit_d   = '0;
          half_d  = '0;
          state_d = SHIFT_LO;
`ifdef LED_SERIALIZER_CHANGE_DETECT_EN
          last_word_d = DATA;
`endif
        end
      end
      SHIFT_LO: begin
        if (half_last) begin
          half_d  = '0;
          state_d = SHIFT_HI;
        end else begin
          half_d = half_q + HCW'(1);
        end
      end
      SHIFT_HI: begin
        // The bit advances only after the external device has seen the full high phase.
        if (half_last) begin
          half_d  = '0;
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          bit_d   = bit_q + BW'(1);
          state_d = (bit_q == LAST_BIT) ? LATCH : SHIFT_LO;
        end else begin
          half_d = half_q + HCW'(1);
        end
      end
      LATCH: begin
        if (half_last) begin
          half_d  = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          half_d = half_q + HCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign READY     = (state_q == IDLE);
  assign SER_CLK   = (state_q == SHIFT_HI);
  assign SER_LATCH = (state_q == LATCH);
  assign SER_DATA  = ((state_q == SHIFT_LO) || (state_q == SHIFT_HI)) && shift_q[WIDTH-1];
  assign DONE      = done_q;

endmodule

// File: tb/tb_led_serializer.sv
// tb/tb_led_serializer.sv - directed bench for led_serializer with HALF=2 and HALF=1 instances.
module tb_led_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] data;
  logic        valid, valid1, sel;
  logic        ready, sdata, sclk, latch, done;
  logic        ready1, sdata1, sclk1, latch1, done1;
  logic        m_ready, m_sdata, m_sclk, m_latch, m_done;

  int checks = 0;
  int failures = 0;

  led_serializer #(.WIDTH(32), .HALF(2)) dut (
    .CLK(clk), .RESET(rst_n), .DATA(data), .VALID(valid), .READY(ready),
    .SER_DATA(sdata), .SER_CLK(sclk), .SER_LATCH(latch), .DONE(done)
  );

  led_serializer #(.WIDTH(32), .HALF(1)) dut1 (
    .CLK(clk), .RESET(rst_n), .DATA(data), .VALID(valid1), .READY(ready1),
    .SER_DATA(sdata1), .SER_CLK(sclk1), .SER_LATCH(latch1), .DONE(done1)
  );

  assign m_ready = sel ? ready1 : ready;
  assign m_sdata = sel ? sdata1 : sdata;
  assign m_sclk  = sel ? sclk1  : sclk;
  assign m_latch = sel ? latch1 : latch;
  assign m_done  = sel ? done1  : done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after the capture edge; observes each cycle until DONE.
  task automatic run_frame(input bit tog, output logic [31:0] word, output int nbits,
                           output int latch_cyc, output int lat_bad, output int done_at,
                           output int ready_hi, output int toggles);
    logic prev;
    word = '0; nbits = 0; latch_cyc = 0; lat_bad = 0; done_at = -1; ready_hi = 0; toggles = 0;
    prev = 1'b0;
    for (int i = 0; i <= 300; i++) begin
      if (m_done) begin
        done_at = i;
        break;
      end
      if (m_ready) ready_hi++;
      if (m_sclk !== prev) toggles++;
      if (m_sclk && !prev) begin
        word = {word[30:0], m_sdata};
        nbits++;
      end
      if (m_latch) begin
        latch_cyc++;
        if (m_sclk || m_sdata) lat_bad++;
      end
      prev = m_sclk;
      tick();
      if (tog) data = $urandom;
    end
  endtask

  logic [31:0] w;
  int nb, lc, lb, da, rh, tg, cnt;

  initial begin
    rst_n = 1'b0; data = '0; valid = 1'b0; valid1 = 1'b0; sel = 1'b0;
    tick(); tick();
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_outs", {28'd0, sdata, sclk, latch, done}, 32'd0);
    rst_n = 1'b1;
    tick();

`ifdef LED_SERIALIZER_CHANGE_DETECT_EN
    cnt = 0;
    for (int i = 0; i < 20; i++) begin valid = 1'b1; tick(); if (!ready) cnt++; end
    valid = 1'b0;
    chk("cd_steady_zero", cnt, 0);
    data = 32'd5;
    tick();
    chk("cd_capture", {31'd0, ready}, 32'd0);
    run_frame(1'b0, w, nb, lc, lb, da, rh, tg);
    chk("cd_word", w, 32'd5);
    chk("cd_done_at", da, 130);
    chk("cd_latch", lc, 2);
    cnt = 0;
    tick();
    for (int i = 0; i < 300; i++) begin tick(); if (!ready) cnt++; end
    chk("cd_held", cnt, 0);
`else
    // Single transfer.
    data = 32'hA500_0001; valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("single_captured", {31'd0, ready}, 32'd0);
    run_frame(1'b0, w, nb, lc, lb, da, rh, tg);
    chk("single_word", w, 32'hA500_0001);
    chk("single_nbits", nb, 32);
    chk("single_latch", lc, 2);
    chk("single_latch_lines", lb, 0);
    chk("single_done_at", da, 130);
    tick();
    chk("single_done_pulse", {31'd0, done}, 32'd0);

    // Back-to-back with VALID held.
    data = 32'hFFFF_FFFF; valid = 1'b1;
    tick();
    data = 32'h0000_0000;
    run_frame(1'b0, w, nb, lc, lb, da, rh, tg);
    chk("b2b_word0", w, 32'hFFFF_FFFF);
    chk("b2b_done0", da, 130);
    chk("b2b_ready0", rh, 0);
    chk("b2b_ready_done_cycle", {31'd0, ready}, 32'd1);
    tick();
    valid = 1'b0;
    chk("b2b_second_capture", {31'd0, ready}, 32'd0);
    run_frame(1'b0, w, nb, lc, lb, da, rh, tg);
    chk("b2b_word1", w, 32'h0000_0000);
    chk("b2b_nbits1", nb, 32);
    chk("b2b_done1", da, 130);
    chk("b2b_ready1", rh, 0);
    tick();

    // Reset during bit 10.
    data = 32'hDEAD_BEEF; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 42; i++) tick();
    chk("mid_busy", {31'd0, ready}, 32'd0);
    rst_n = 1'b0; valid = 1'b1;
    tick();
    chk("mid_rst_ready", {31'd0, ready}, 32'd1);
    chk("mid_rst_outs", {28'd0, sdata, sclk, latch, done}, 32'd0);
    tick();
    chk("mid_rst_valid_ignored", {31'd0, ready}, 32'd1);
    valid = 1'b0;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin tick(); if (latch || done || !ready) cnt++; end
    chk("mid_no_latch_done", cnt, 0);
    data = 32'h0F0F_3C3C; valid = 1'b1;
    tick();
    valid = 1'b0;
    run_frame(1'b0, w, nb, lc, lb, da, rh, tg);
    chk("post_rst_word", w, 32'h0F0F_3C3C);
    chk("post_rst_done", da, 130);
    tick();

    // DATA churn during transfer.
    data = 32'h1234_5678; valid = 1'b1;
    tick();
    valid = 1'b0;
    run_frame(1'b1, w, nb, lc, lb, da, rh, tg);
    chk("stable_word", w, 32'h1234_5678);
    chk("stable_nbits", nb, 32);
    tick();

    // HALF=1 instance.
    sel = 1'b1;
    data = 32'h8000_0000; valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    run_frame(1'b0, w, nb, lc, lb, da, rh, tg);
    chk("h1_word", w, 32'h8000_0000);
    chk("h1_done_at", da, 65);
    chk("h1_toggles", tg, 64);
    chk("h1_latch", lc, 1);
    sel = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
